axi_lite_register_master: RTL and testbench

AXI4-Lite initiator that turns single register commands into AXI4-Lite read or write transactions. It drives the slave port of `frequency_analyzer_manager` and any other register-mapped peripheral in the design. It allows sequencers and test logic to program thresholds and frequency limits and to read status without a processor. One transaction is in flight at a time, with a bounded timeout so a dead slave cannot hang the requester.

---
 rtl/axi_lite_register_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_lite_register_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_register_master.sv
// AXI4-Lite initiator: turns one register command at a time into a read or write
// transaction and returns a single response, aborting after a bounded number of cycles.
module axi_lite_register_master #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_areset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                rsp_timeout,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);
    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int SW = C_M00_AXI_DATA_WIDTH / 8;
    // One spare count above the limit so the counter can keep running in WB/RD
    // after a handshake won against a firing timeout.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_AR, S_RD, S_RSP} state_t;

    state_t            r_state,     w_state_nxt;
    logic              r_aw_done,   w_aw_done_nxt;
    logic              r_w_done,    w_w_done_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [AW-1:0]     r_awaddr,    w_awaddr_nxt;
    logic              r_awvalid,   w_awvalid_nxt;
    logic [DW-1:0]     r_wdata,     w_wdata_nxt;
    logic [SW-1:0]     r_wstrb,     w_wstrb_nxt;
    logic              r_wvalid,    w_wvalid_nxt;
    logic              r_bready,    w_bready_nxt;
    logic [AW-1:0]     r_araddr,    w_araddr_nxt;
    logic              r_arvalid,   w_arvalid_nxt;
    logic              r_rready,    w_rready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]        r_rsp_resp,  w_rsp_resp_nxt;
    logic              r_rsp_tmo,   w_rsp_tmo_nxt;

    logic              w_aw_hs, w_w_hs, w_aw_done_now, w_w_done_now;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_tmo, w_abort;

    assign w_aw_hs       = r_awvalid & m00_axi_awready;
    assign w_w_hs        = r_wvalid & m00_axi_wready;
    assign w_aw_done_now = r_aw_done | w_aw_hs;
    assign w_w_done_now  = r_w_done | w_w_hs;
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_tmo         = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= TMO);

    always_comb begin
        w_state_nxt     = r_state;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_cnt_nxt       = r_cnt;
        w_awaddr_nxt    = r_awaddr;
        w_awvalid_nxt   = r_awvalid;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_rsp_tmo_nxt   = r_rsp_tmo;
        w_abort         = 1'b0;

        if (r_state == S_WR || r_state == S_WB || r_state == S_AR || r_state == S_RD)
            w_cnt_nxt = w_cnt_inc;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_cnt_nxt     = '0;
                    w_awaddr_nxt  = cmd_addr;
                    w_araddr_nxt  = cmd_addr;
                    w_wdata_nxt   = cmd_wdata;
                    w_wstrb_nxt   = cmd_wstrb;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    if (cmd_write) begin
                        w_state_nxt   = S_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_AR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WR: begin
                w_aw_done_nxt = w_aw_done_now;
                w_w_done_nxt  = w_w_done_now;
                if (w_aw_done_now && w_w_done_now) begin
                    w_state_nxt   = S_WB;
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_bready_nxt  = 1'b1;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end else begin
                    w_awvalid_nxt = ~w_aw_done_now;
                    w_wvalid_nxt  = ~w_w_done_now;
                end
            end
            S_WB: begin
                if (m00_axi_bvalid) begin
                    w_state_nxt     = S_RSP;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = m00_axi_bresp;
                    w_rsp_tmo_nxt   = 1'b0;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            S_AR: begin
                if (m00_axi_arready) begin
                    w_state_nxt   = S_RD;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            S_RD: begin
                if (m00_axi_rvalid) begin
                    w_state_nxt     = S_RSP;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = m00_axi_rdata;
                    w_rsp_resp_nxt  = m00_axi_rresp;
                    w_rsp_tmo_nxt   = 1'b0;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A dead slave: drop every handshake signal and report SLVERR-style timeout.
        if (w_abort) begin
            w_state_nxt     = S_RSP;
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_bready_nxt    = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_rsp_resp_nxt  = 2'b10;
            w_rsp_tmo_nxt   = 1'b1;
        end
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            r_state     <= S_IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_cnt       <= '0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_cnt       <= w_cnt_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_rsp_tmo   <= w_rsp_tmo_nxt;
        end
    end

    assign cmd_ready       = (r_state == S_IDLE) && !m00_axi_areset;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_resp        = r_rsp_resp;
    assign rsp_timeout     = r_rsp_tmo;
    assign m00_axi_awaddr  = r_awaddr;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = r_awvalid;
    assign m00_axi_wdata   = r_wdata;
    assign m00_axi_wstrb   = r_wstrb;
    assign m00_axi_wvalid  = r_wvalid;
    assign m00_axi_bready  = r_bready;
    assign m00_axi_araddr  = r_araddr;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = r_arvalid;
    assign m00_axi_rready  = r_rready;
endmodule

// File: tb/tb_axi_lite_register_master.sv
// Bench for axi_lite_register_master: directed commands against a configurable-latency
// AXI4-Lite slave, expected responses queued at issue and checked by a separate monitor.
module tb_axi_lite_register_master;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [9:0]  m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    axi_lite_register_master #(
        .C_M00_AXI_DATA_WIDTH(32), .C_M00_AXI_ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m00_axi_awaddr(m_awaddr), .m00_axi_awprot(m_awprot), .m00_axi_awvalid(m_awvalid),
        .m00_axi_awready(m_awready), .m00_axi_wdata(m_wdata), .m00_axi_wstrb(m_wstrb),
        .m00_axi_wvalid(m_wvalid), .m00_axi_wready(m_wready), .m00_axi_bresp(m_bresp),
        .m00_axi_bvalid(m_bvalid), .m00_axi_bready(m_bready), .m00_axi_araddr(m_araddr),
        .m00_axi_arprot(m_arprot), .m00_axi_arvalid(m_arvalid), .m00_axi_arready(m_arready),
        .m00_axi_rdata(m_rdata), .m00_axi_rresp(m_rresp), .m00_axi_rvalid(m_rvalid),
        .m00_axi_rready(m_rready)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Slave configuration, written by the stimulus process between transactions.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = '0;
    logic        s_clr = 1'b0;
    int          b_hs_cnt = 0;

    logic sl_aw_hs, sl_w_hs, sl_b_hs, sl_ar_hs, sl_r_hs, sl_aw_done, sl_w_done, sl_ar_done;
    int   sl_aw_c, sl_w_c, sl_b_c, sl_ar_c;

    // Slave: all drives on the falling edge; a handshake is valid&ready seen then.
    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        sl_aw_hs = 0; sl_w_hs = 0; sl_b_hs = 0; sl_ar_hs = 0; sl_r_hs = 0;
        sl_aw_done = 0; sl_w_done = 0; sl_ar_done = 0;
        sl_aw_c = 0; sl_w_c = 0; sl_b_c = 0; sl_ar_c = 0;
        forever begin
            @(negedge clk);
            if (areset || s_clr) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                sl_aw_hs = 0; sl_w_hs = 0; sl_b_hs = 0; sl_ar_hs = 0; sl_r_hs = 0;
                sl_aw_done = 0; sl_w_done = 0; sl_ar_done = 0;
                sl_aw_c = 0; sl_w_c = 0; sl_b_c = 0; sl_ar_c = 0;
            end else begin
                if (sl_aw_hs) sl_aw_done = 1;
                if (sl_w_hs)  sl_w_done = 1;
                if (sl_ar_hs) sl_ar_done = 1;
                if (sl_b_hs) begin m_bvalid = 0; b_hs_cnt++; end
                if (sl_r_hs) m_rvalid = 0;
                m_awready = 0;
                if (m_awvalid) begin
                    if (sl_aw_c >= aw_dly) begin m_awready = 1; sl_aw_c = 0; end else sl_aw_c++;
                end
                m_wready = 0;
                if (m_wvalid) begin
                    if (sl_w_c >= w_dly) begin m_wready = 1; sl_w_c = 0; end else sl_w_c++;
                end
                m_arready = 0;
                if (m_arvalid) begin
                    if (sl_ar_c >= ar_dly) begin m_arready = 1; sl_ar_c = 0; end else sl_ar_c++;
                end
                if (sl_aw_done && sl_w_done && !m_bvalid) begin
                    if (sl_b_c >= b_dly) begin
                        m_bvalid = 1; m_bresp = s_bresp; sl_aw_done = 0; sl_w_done = 0; sl_b_c = 0;
                    end else sl_b_c++;
                end
                if (sl_ar_done && !m_rvalid) begin
                    m_rvalid = 1; m_rdata = s_rdata; m_rresp = s_rresp; sl_ar_done = 0;
                end
                sl_aw_hs = m_awvalid && m_awready;
                sl_w_hs  = m_wvalid && m_wready;
                sl_ar_hs = m_arvalid && m_arready;
                sl_b_hs  = m_bvalid && m_bready;
                sl_r_hs  = m_rvalid && m_rready;
            end
        end
    end

    // Monitor: every response handshake pops and compares one expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (areset !== 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual=rsp_valid=1 required=no response");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_resp", {30'd0, rsp_resp}, {30'd0, mon_e.resp});
                    check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, mon_e.tmo});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    // Returns on the falling edge of the first cycle after the accept edge.
    task automatic send(input logic wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic push, input rsp_t e);
        int n;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        if (push) exp_q.push_back(e);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check(name, exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic clear_slave();
        s_clr = 1; @(negedge clk); @(negedge clk); s_clr = 0;
    endtask

    int   cnt_aw, cnt_w, cnt_ar, b0;
    logic stable, held;
    rsp_t snap;

    initial begin
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid,
                                rsp_timeout, cmd_ready}, 32'd0);
        check("reset_addr", {m_awaddr, m_araddr}, 32'd0);
        areset = 0;
        @(negedge clk);
        check("reset_release_ready", {31'd0, cmd_ready}, 32'd1);

        // Zero-wait write
        b0 = b_hs_cnt;
        send(1'b1, 10'h010, 32'h0000_0064, 4'hF, 1'b1, '{32'h0, 2'b00, 1'b0});
        check("wr0_valids_n1", {m_awvalid, m_wvalid}, 32'b11);
        check("wr0_awaddr", {22'd0, m_awaddr}, 32'h010);
        check("wr0_wdata", m_wdata, 32'h64);
        check("wr0_wstrb", {28'd0, m_wstrb}, 32'hF);
        @(negedge clk);
        check("wr0_bready_n2", {m_bready, m_awvalid, m_wvalid}, 32'b100);
        @(negedge clk);
        check("wr0_rsp_valid_n3", {31'd0, rsp_valid}, 32'd1);
        wait_done("wr0_done");
        check("wr0_b_hs", b_hs_cnt - b0, 32'd1);

        // AW immediate, W delayed by 4, then the mirror case
        for (int pass = 0; pass < 2; pass++) begin
            aw_dly = (pass == 0) ? 0 : 4;
            w_dly  = (pass == 0) ? 4 : 0;
            b0 = b_hs_cnt;
            send(1'b1, 10'h014, 32'h0000_00AB, 4'h3, 1'b1, '{32'h0, 2'b00, 1'b0});
            cnt_aw = 0; cnt_w = 0; stable = 1;
            while ((m_awvalid || m_wvalid) && (cnt_aw + cnt_w) < 40) begin
                if (m_awvalid) begin cnt_aw++; if (m_awaddr !== 10'h014) stable = 0; end
                if (m_wvalid)  begin cnt_w++;  if (m_wdata !== 32'hAB)   stable = 0; end
                @(negedge clk);
            end
            check((pass == 0) ? "wlate_aw_cycles" : "awlate_aw_cycles", cnt_aw, (pass == 0) ? 1 : 5);
            check((pass == 0) ? "wlate_w_cycles" : "awlate_w_cycles", cnt_w, (pass == 0) ? 5 : 1);
            check("split_stable", {31'd0, stable}, 32'd1);
            wait_done("split_done");
            check("split_b_hs", b_hs_cnt - b0, 32'd1);
        end
        aw_dly = 0; w_dly = 0;

        // Read with 3-cycle arready delay
        ar_dly = 3; s_rdata = 32'hDEADBEEF; s_rresp = 2'b00;
        send(1'b0, 10'h020, 32'h0, 4'h0, 1'b1, '{32'hDEADBEEF, 2'b00, 1'b0});
        cnt_ar = 0; stable = 1;
        while (m_arvalid && cnt_ar < 40) begin
            cnt_ar++;
            if (m_araddr !== 10'h020) stable = 0;
            @(negedge clk);
        end
        check("rd_ar_cycles", cnt_ar, 32'd4);
        check("rd_araddr_stable", {31'd0, stable}, 32'd1);
        wait_done("rd_done");
        ar_dly = 0;

        // Error responses passed through
        s_bresp = 2'b10;
        send(1'b1, 10'h018, 32'h1234_0000, 4'hC, 1'b1, '{32'h0, 2'b10, 1'b0});
        wait_done("bresp_done");
        s_bresp = 2'b00; s_rresp = 2'b11; s_rdata = 32'h1234_5678;
        send(1'b0, 10'h01C, 32'h0, 4'h0, 1'b1, '{32'h1234_5678, 2'b11, 1'b0});
        wait_done("rresp_done");
        s_rresp = 2'b00;

        // Timeout with awready stuck low
        aw_dly = 1000;
        send(1'b1, 10'h030, 32'h55, 4'hF, 1'b1, '{32'h0, 2'b10, 1'b1});
        held = 1;
        for (int k = 1; k <= 16; k++) begin
            if (!(m_awvalid === 1'b1 && rsp_valid === 1'b0)) held = 0;
            @(negedge clk);
        end
        check("tmo_held_16", {31'd0, held}, 32'd1);
        check("tmo_abort_17", {m_awvalid, rsp_valid}, 32'b01);
        wait_done("tmo_done");
        aw_dly = 0;
        clear_slave();
        s_rdata = 32'h0BAD_F00D;
        send(1'b0, 10'h024, 32'h0, 4'h0, 1'b1, '{32'h0BAD_F00D, 2'b00, 1'b0});
        wait_done("post_tmo_rd_done");

        // Backpressured response
        rsp_ready = 0; s_rdata = 32'hA5A5_0001;
        send(1'b0, 10'h028, 32'h0, 4'h0, 1'b1, '{32'hA5A5_0001, 2'b00, 1'b0});
        cnt_ar = 0;
        while (rsp_valid !== 1'b1 && cnt_ar < 20) begin @(negedge clk); cnt_ar++; end
        snap = '{rsp_rdata, rsp_resp, rsp_timeout};
        stable = 1;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== snap.rdata ||
                rsp_resp !== snap.resp || rsp_timeout !== snap.tmo) stable = 0;
            @(negedge clk);
        end
        check("hold_stable", {31'd0, stable}, 32'd1);
        rsp_ready = 1;
        wait_done("hold_done");

        // Reset while waiting for B
        b_dly = 5;
        send(1'b1, 10'h02C, 32'h77, 4'hF, 1'b0, '{32'h0, 2'b00, 1'b0});
        @(negedge clk);
        check("rst_in_wb", {31'd0, m_bready}, 32'd1);
        areset = 1;
        @(negedge clk);
        check("rst_outputs", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid,
                              rsp_timeout, cmd_ready}, 32'd0);
        check("rst_data", {m_wdata[21:0], m_awaddr}, 32'd0);
        areset = 0;
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        b_dly = 0;
        clear_slave();
        held = 1;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid !== 1'b0) held = 0;
            @(negedge clk);
        end
        check("rst_no_rsp", {31'd0, held}, 32'd1);

        s_rdata = 32'h0000_0064;
        send(1'b0, 10'h010, 32'h0, 4'h0, 1'b1, '{32'h0000_0064, 2'b00, 1'b0});
        wait_done("final_rd_done");

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
